// File: rtl/gshare_predictor_pkg.sv
// Shared branch-prediction definitions.
//   bp_state_e : table state machine (sweep-initialise, then run)
//   weak_nt    : counter reset value (weakly not-taken) for a given width
//   sat_update : saturating up/down step of a direction counter
//   bp_index   : table index from PC bits, optionally XORed with history
package gshare_predictor_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Weakly not-taken: 2^(ctr_bits-1) - 1 (01 for 2-bit counters).
    function automatic int unsigned weak_nt(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    // Saturating +1 on taken, -1 on not-taken; sticks at 0 and at 2^ctr_bits-1.
    function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int unsigned ctr_bits);
        logic [31:0] max_v;
        max_v = (32'd1 << ctr_bits) - 32'd1;
        if (taken && ctr != max_v)
            return ctr + 32'd1;
        else if (!taken && ctr != 32'd0)
            return ctr - 32'd1;
        return ctr;
    endfunction

    // pc[pc_lsb +: index_bits], XORed with zero-extended history in gshare mode.
    function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                             input logic [31:0] hist,
                                             input logic        gshare,
                                             input int unsigned index_bits,
                                             input int unsigned pc_lsb);
        logic [31:0] mask;
        mask = (32'd1 << index_bits) - 32'd1;
        return ((pc >> pc_lsb) ^ (gshare ? hist : 32'd0)) & mask;
    endfunction

endpackage

// File: rtl/gshare_predictor_table.sv
// Direction-counter storage: DEPTH x CTR_BITS.
//   rd_f_addr/rd_f_data : async read port for the fetch-side lookup
//   rd_u_addr/rd_u_data : async read port for update read-modify-write
//   we/waddr/wdata      : single synchronous write port
// No reset: contents are defined by the predictor's init sweep.
module bp_counter_table #(
    parameter int INDEX_BITS = 10,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_f_addr,
    output logic [CTR_BITS-1:0]   rd_f_data,
    input  logic [INDEX_BITS-1:0] rd_u_addr,
    output logic [CTR_BITS-1:0]   rd_u_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] waddr,
    input  logic [CTR_BITS-1:0]   wdata
);
    localparam int DEPTH = 1 << INDEX_BITS;

    logic [CTR_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem_q[waddr] <= wdata;
    end

    // Reads see the pre-write value; a same-cycle write lands at the edge.
    assign rd_f_data = mem_q[rd_f_addr];
    assign rd_u_data = mem_q[rd_u_addr];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor.
//   clk, reset_n            : clock, async active-low reset
//   flush                   : re-sweep the table and clear history
//   ready                   : table initialised, predictions valid
//   fetch_valid, fetch_pc   : IF lookup; predict_taken/predict_hist returned same cycle
//   update_*                : EX resolution; trains the table, repairs history on mispredict
//   mispred_cnt             : saturating mispredict count (cleared by reset_n only)
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 8,
    parameter int PC_LSB     = 2,
    parameter int MODE       = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    output logic                 ready,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    output logic                 predict_taken,
    output logic [HIST_BITS-1:0] predict_hist,
    input  logic                 update_valid,
    input  logic [31:0]          update_pc,
    input  logic [HIST_BITS-1:0] update_hist,
    input  logic                 update_taken,
    input  logic                 update_mispredict,
    output logic [15:0]          mispred_cnt
);
    localparam logic [CTR_BITS-1:0] WEAK_NT_V = CTR_BITS'(weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_HALF  = CTR_BITS'(32'd1 << (CTR_BITS - 1));
    localparam logic                GSHARE    = (MODE != 0);

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [15:0]           mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] fetch_idx, upd_idx, tbl_waddr;
    logic [CTR_BITS-1:0]   rd_f, rd_u, upd_next, tbl_wdata;
    logic                  tbl_we, mispred_evt;

    assign fetch_idx = INDEX_BITS'(bp_index(fetch_pc, 32'(ghr_q), GSHARE, INDEX_BITS, PC_LSB));
    assign upd_idx   = INDEX_BITS'(bp_index(update_pc, 32'(update_hist), GSHARE, INDEX_BITS, PC_LSB));
    assign upd_next  = CTR_BITS'(sat_update(32'(rd_u), update_taken, CTR_BITS));

    bp_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_table (
        .clk       (clk),
        .rd_f_addr (fetch_idx),
        .rd_f_data (rd_f),
        .rd_u_addr (upd_idx),
        .rd_u_data (rd_u),
        .we        (tbl_we),
        .waddr     (tbl_waddr),
        .wdata     (tbl_wdata)
    );

    assign ready         = (state_q == ST_RUN);
    // Counter MSB set <=> counter >= 2^(CTR_BITS-1).
    assign predict_taken = ready && (rd_f >= CTR_HALF);
    assign predict_hist  = ready ? ghr_q : '0;
    assign mispred_cnt   = mispred_cnt_q;
    assign mispred_evt   = update_valid && update_mispredict;

    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        ghr_d         = ghr_q;
        mispred_cnt_d = mispred_cnt_q;
        tbl_we        = 1'b0;
        tbl_waddr     = upd_idx;
        tbl_wdata     = upd_next;

        if (state_q == ST_INIT) begin
            // Sweep one entry per cycle; the write port belongs to the sweep here.
            tbl_we     = 1'b1;
            tbl_waddr  = init_ptr_q;
            tbl_wdata  = WEAK_NT_V;
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == '1)
                state_d = ST_RUN;
        end else begin
            tbl_we = update_valid;
            // Recovery from the resolved branch beats the speculative shift.
            if (mispred_evt)
                ghr_d = HIST_BITS'({update_hist, update_taken});
            else if (fetch_valid)
                ghr_d = HIST_BITS'({ghr_q, predict_taken});
            if (mispred_evt && mispred_cnt_q != 16'hFFFF)
                mispred_cnt_d = mispred_cnt_q + 16'd1;
        end

        // Flush restarts the sweep; a same-cycle training write still happens
        // and is simply overwritten later by the sweep.
        if (flush) begin
            state_d    = ST_INIT;
            init_ptr_d = '0;
            ghr_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_INIT;
            init_ptr_q    <= '0;
            ghr_q         <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            ghr_q         <= ghr_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: one gshare instance and one bimodal instance
// share stimulus; each is compared every cycle with a table/array model,
// plus hand-derived vectors and directed corner-case sequences.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, flush, fetch_valid, update_valid, update_taken, update_mispredict;
    logic [31:0] fetch_pc, update_pc;
    logic [7:0]  update_hist;

    logic        rdy [2];
    logic        pt  [2];
    logic [7:0]  ph  [2];
    logic [15:0] mc  [2];

    gshare_predictor #(.MODE(1)) dut_g (
        .clk(clk), .reset_n(reset_n), .flush(flush), .ready(rdy[0]),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .predict_taken(pt[0]), .predict_hist(ph[0]),
        .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
        .update_taken(update_taken), .update_mispredict(update_mispredict),
        .mispred_cnt(mc[0])
    );

    gshare_predictor #(.MODE(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .ready(rdy[1]),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .predict_taken(pt[1]), .predict_hist(ph[1]),
        .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
        .update_taken(update_taken), .update_mispredict(update_mispredict),
        .mispred_cnt(mc[1])
    );

    // ---------------- reference model (m = 0 gshare, m = 1 bimodal) ----------------
    int m_tbl [2][1024];
    int m_ghr [2];
    int m_cyc;          // cycles since sweep start; ready once it reaches 1024
    int m_cnt;
    int tests = 0;
    int fails = 0;

    function automatic int midx(int m, logic [31:0] pc, int hist);
        int p;
        p = int'((pc >> 2) % 1024);
        return (m == 0) ? (p ^ hist) : p;
    endfunction

    function automatic int m_pred(int m);
        if (m_cyc < 1024) return 0;
        return (m_tbl[m][midx(m, fetch_pc, m_ghr[m])] >= 2) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_cnt = 0; m_ghr[0] = 0; m_ghr[1] = 0;
    endtask

    task automatic model_clock();
        int p [2];
        int ix;
        if (m_cyc < 1024) begin
            if (flush) m_cyc = 0;
            else begin
                m_cyc++;
                if (m_cyc == 1024)
                    for (int m = 0; m < 2; m++)
                        for (int k = 0; k < 1024; k++) m_tbl[m][k] = 1;
            end
        end else begin
            for (int m = 0; m < 2; m++) p[m] = m_pred(m);
            for (int m = 0; m < 2; m++) begin
                if (update_valid) begin
                    ix = midx(m, update_pc, int'(update_hist));
                    if (update_taken) m_tbl[m][ix] = (m_tbl[m][ix] < 3) ? m_tbl[m][ix] + 1 : 3;
                    else              m_tbl[m][ix] = (m_tbl[m][ix] > 0) ? m_tbl[m][ix] - 1 : 0;
                end
                if (update_valid && update_mispredict)
                    m_ghr[m] = ((int'(update_hist) * 2) + (update_taken ? 1 : 0)) % 256;
                else if (fetch_valid)
                    m_ghr[m] = ((m_ghr[m] * 2) + p[m]) % 256;
            end
            if (update_valid && update_mispredict && m_cnt < 65535) m_cnt++;
            if (flush) begin
                m_cyc = 0; m_ghr[0] = 0; m_ghr[1] = 0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_now();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("ready%0d", m), 32'(rdy[m]), (m_cyc >= 1024) ? 1 : 0);
            chk($sformatf("pred%0d", m), 32'(pt[m]), m_pred(m));
            chk($sformatf("hist%0d", m), 32'(ph[m]), (m_cyc >= 1024) ? m_ghr[m] : 0);
            chk($sformatf("mcnt%0d", m), 32'(mc[m]), m_cnt);
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_clock();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_now();
        clock_edge();
    endtask

    task automatic drive(bit fv, logic [31:0] fpc, bit uv, logic [31:0] upc,
                         int uh, bit ut, bit um, bit fl);
        fetch_valid = fv; fetch_pc = fpc; update_valid = uv; update_pc = upc;
        update_hist = 8'(uh); update_taken = ut; update_mispredict = um; flush = fl;
    endtask

    // Step until ready (bounded); returns edges taken.
    task automatic wait_ready(inout int n);
        while (n < 1100) begin
            step();
            n++;
            if (rdy[0] === 1'b1) break;
        end
    endtask

    typedef struct {
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        bit          exp_b;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int n;
        int cnt_save;

        // Bimodal counter at pc 0x40, starting at 01; expected is the pre-edge value's MSB.
        vecs[0] = '{1'b1, 32'h40, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h40, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'h40, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h40, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h40, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'h40, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h40, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h40, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 32'h40, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 32'h40, 1'b0, 1'b0};

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;

        // Sweep from reset: no predictions while initialising.
        n = 0;
        drive(0, 32'h0, 0, 0, 0, 0, 0, 0);     @(negedge clk); chk("init_pred_0", 32'(pt[0]), 0); check_now(); clock_edge(); n++;
        drive(0, 32'h40, 0, 0, 0, 0, 0, 0);    @(negedge clk); chk("init_pred_40", 32'(pt[0]), 0); check_now(); clock_edge(); n++;
        drive(0, 32'hFFC, 0, 0, 0, 0, 0, 0);   @(negedge clk); chk("init_pred_ffc", 32'(pt[1]), 0); check_now(); clock_edge(); n++;
        wait_ready(n);
        chk("init_ready_latency", n, 1024);

        // Table-driven bimodal saturation sequence.
        for (int i = 0; i < 10; i++) begin
            drive(0, 32'h40, vecs[i].uv, vecs[i].upc, 0, vecs[i].ut, 0, 0);
            @(negedge clk);
            check_now();
            chk($sformatf("vec%0d_bimodal", i), 32'(pt[1]), 32'(vecs[i].exp_b));
            clock_edge();
        end

        // Gshare indexing: train idx 0x15 via hist 0x05, then set GHR through recovery.
        drive(0, 32'h40, 1, 32'h40, 8'h05, 1, 0, 0);  step();
        drive(0, 32'h40, 1, 32'h800, 8'h02, 1, 1, 0); step();
        drive(0, 32'h40, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("gs_ghr05_hist", 32'(ph[0]), 32'h05);
        chk("gs_ghr05_pred", 32'(pt[0]), 1);
        check_now(); clock_edge();
        drive(0, 32'h40, 1, 32'h800, 8'h00, 0, 1, 0); step();
        drive(0, 32'h40, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("gs_ghr00_pred", 32'(pt[0]), 0);
        check_now(); clock_edge();

        // Speculative shift then recovery with a concurrent fetch.
        for (int h = 0; h < 4; h++) begin
            if (h == 2) continue;
            drive(0, 32'h1000, 1, 32'h1000, h, 1, 0, 0); step(); step();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h1000, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("spec_pred%0d", k), 32'(pt[0]), 1);
            check_now(); clock_edge();
        end
        drive(1, 32'h1000, 1, 32'h2000, 8'h12, 0, 1, 0);
        @(negedge clk);
        chk("spec_ghr07_g", 32'(ph[0]), 32'h07);
        chk("spec_ghr07_b", 32'(ph[1]), 32'h07);
        check_now(); clock_edge();
        drive(0, 32'h100, 1, 32'h100, 8'h24, 1, 0, 0);
        @(negedge clk);
        chk("recover_ghr24_g", 32'(ph[0]), 32'h24);
        chk("recover_ghr24_b", 32'(ph[1]), 32'h24);
        // Same-index fetch + taken update: old value now, new value next cycle.
        chk("raw_same_cycle_g", 32'(pt[0]), 0);
        chk("raw_same_cycle_b", 32'(pt[1]), 0);
        check_now(); clock_edge();
        drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("raw_next_cycle_g", 32'(pt[0]), 1);
        chk("raw_next_cycle_b", 32'(pt[1]), 1);
        check_now(); clock_edge();

        // Randomised traffic, with occasional flushes.
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)) << 2,
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)) << 2,
                  int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1499) == 0));
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n = 0;
        if (rdy[0] !== 1'b1) wait_ready(n);
        chk("rand_ready_restored", 32'(rdy[0]), 1);

        // Flush in RUN: ready drops, returns after the sweep, count kept.
        cnt_save = m_cnt;
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_ready_drop", 32'(rdy[0]), 0);
        n = 0;
        wait_ready(n);
        chk("flush_ready_latency", n, 1024);
        chk("flush_keeps_cnt", 32'(mc[0]), 32'(cnt_save));

        // Reset mid-sweep restarts the sweep and clears the count.
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (500) step();
        reset_n = 1'b0;
        model_reset();
        step(); step();
        reset_n = 1'b1;
        n = 0;
        wait_ready(n);
        chk("reset_ready_latency", n, 1024);
        chk("reset_clears_cnt_g", 32'(mc[0]), 0);
        chk("reset_clears_cnt_b", 32'(mc[1]), 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised direction predictor for the five-stage pipeline: table of CTR_BITS-wide saturating counters, indexed by PC bits XOR a global history register (gshare), with bimodal fallback mode.
- Queried combinationally in IF; trained from EX on branch resolution.
- Speculative history with mispredict recovery; table initialised by a sweep FSM instead of a bulk reset.

Parameters:
- INDEX_BITS, 10, log2 of table depth; DEPTH = 2^INDEX_BITS.
- CTR_BITS, 2, counter width (>=2).
- HIST_BITS, 8, global history length (1..INDEX_BITS).
- PC_LSB, 2, lowest PC bit used for indexing.
- MODE, 1, 1 = gshare, 0 = bimodal (history ignored for indexing, still tracked).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  re-initialise table and history.
- ready  out  1  table initialised; predictions valid.
- fetch_valid  in  1  IF lookup this cycle.
- fetch_pc  in  32  PC of fetched instruction.
- predict_taken  out  1  predicted direction.
- predict_hist  out  HIST_BITS  GHR snapshot used for this lookup; carried down the pipe.
- update_valid  in  1  branch resolved this cycle.
- update_pc  in  32  PC of resolved branch.
- update_hist  in  HIST_BITS  snapshot returned from predict_hist.
- update_taken  in  1  actual outcome.
- update_mispredict  in  1  outcome differed from prediction.
- mispred_cnt  out  16  saturating mispredict count.

Behaviour:
- Index: pidx = pc[PC_LSB +: INDEX_BITS].
  - gshare: idx = pidx XOR zero-extended hist.
  - bimodal: idx = pidx.
  - Fetch side uses fetch_pc with the GHR; update side uses update_pc with update_hist.
- Counter reset value WEAK_NT = 2^(CTR_BITS-1)-1 (01 for 2 bits).
- Prediction: combinational, same cycle; predict_taken = MSB of table[fetch idx] when ready, else 0.
- predict_hist = GHR when ready, else 0.
- Training: on update_valid && ready, table[upd idx] saturating +1 if taken, -1 if not. No change at max (2^CTR_BITS-1) or at 0.
- Speculative GHR: on fetch_valid && ready, GHR <= {GHR[HIST_BITS-2:0], predict_taken}.
- Recovery: on update_valid && update_mispredict && ready, GHR <= {update_hist[HIST_BITS-2:0], update_taken}. This has priority over a same-cycle fetch shift.
- Same-index fetch and update in one cycle: fetch sees the pre-update value (read-before-write). The write lands at the clock edge.
- mispred_cnt: +1 per update_valid && update_mispredict && ready; saturates at 0xFFFF; cleared only by reset_n. Flush does not clear it.
- FSM states:
  - INIT: write table[init_ptr] = WEAK_NT, one entry per cycle; init_ptr += 1. After writing DEPTH-1, go to RUN.
  - RUN: ready = 1.
- Reset (reset_n low, any state, including mid-sweep): state = INIT, init_ptr = 0, GHR = 0, ready = 0, mispred_cnt = 0. Table contents undefined until the sweep completes.
- Timing: ready rises on the DEPTH-th rising edge after reset_n deasserts (cycle 1024 for the default).
- During INIT: fetches are ignored (no GHR shift), updates are dropped, predict_taken = 0.
- flush in RUN: go to INIT next edge, init_ptr = 0, GHR = 0, ready low next cycle. Same-cycle update is still applied, but the sweep overwrites it.
- flush in INIT: restart the sweep at init_ptr = 0.
- Single write port. INIT writes and training writes are mutually exclusive by state.

Decomposition:
- Shared branch-prediction package:
  - FSM state enum {INIT, RUN}.
  - Function sat_update(ctr, taken) parametrised on CTR_BITS.
  - Function bp_index(pc, hist, mode).
  - Constant WEAK_NT.
- One sub-module: bp_counter_table. Holds the DEPTH x CTR_BITS storage with one async read port (fetch), one async read port (update read-modify-write) and one write port.
- FSM, GHR and statistics stay in gshare_predictor.

Test Plan:
- Release reset_n, defaults -> ready = 0 for cycles 0..1023, 1 from cycle 1024; predict_taken = 0 for fetch_pc 0x0, 0x40, 0xFFC.
- MODE=0, two taken updates on pc 0x40 -> counter 01->10->11, fetch 0x40 predicts 1. Four not-taken updates -> 00 (saturates, no wrap to 11), predicts 0.
- MODE=1, pc 0x40 (pidx 0x010): train taken with update_hist 0x05 (idx 0x015) -> fetch 0x40 with GHR 0x05 predicts 1, with GHR 0x00 predicts 0.
- Three fetches predicting taken from GHR 0x00 -> GHR 0x07. Then update_mispredict with update_hist 0x12, taken 0, concurrent with fetch_valid -> GHR 0x24 next cycle.
- Fetch and taken update on the same idx, counter 01, same cycle -> predict_taken 0 that cycle, 1 the next.
- Assert flush in RUN -> ready drops next cycle and returns 1024 cycles later; mispred_cnt unchanged. Pulse reset_n at sweep cycle 500 -> sweep restarts, ready at 1024 cycles after the new release, mispred_cnt = 0.
